rc4_task_sequencer: RTL and testbench

RC4_TASK_SEQUENCER -- requirements
Module: rc4_task_sequencer

---
 rtl/rc4_pkg.sv | 40 ++++
 rtl/rc4_sram_mux.sv | 45 ++++
 rtl/rc4_task_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rc4_task_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search sequencer: FSM states, task selector
// and the widths of the key and the S-RAM port.
package rc4_pkg;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_SHUF_GO,
    ST_SHUF_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_NEXT_KEY,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    TASK_NONE,
    TASK_INIT,
    TASK_SHUF,
    TASK_DEC
  } task_sel_e;

  // Which task owns the S-RAM while the sequencer sits in a given state.
  function automatic task_sel_e task_of_state(input seq_state_e s);
    task_sel_e t;
    case (s)
      ST_INIT_GO, ST_INIT_WAIT: t = TASK_INIT;
      ST_SHUF_GO, ST_SHUF_WAIT: t = TASK_SHUF;
      ST_DEC_GO,  ST_DEC_WAIT:  t = TASK_DEC;
      default:                  t = TASK_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rc4_sram_mux.sv
// Combinational 3:1 S-RAM port mux; an unselected task can never reach the
// shared port, and with no task selected the port is driven to all zeros.
module rc4_sram_mux
  import rc4_pkg::*;
(
  input  task_sel_e         sel,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [DATA_W-1:0] shuf_data,
  input  logic              shuf_wren,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              dec_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  output logic              s_wren
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    case (sel)
      TASK_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      TASK_SHUF: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
      TASK_DEC: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_task_sequencer.sv
// Brute-force RC4 key search: runs init/shuffle/decrypt tasks per candidate key.
// Optional per-task watchdog enabled by defining RC4_SEQ_TIMEOUT_EN.
module rc4_task_sequencer
  import rc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_MAX        = 24'h3FFFFF,
  parameter int unsigned      TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  output logic              Init_Start,
  output logic              Shuf_Start,
  output logic              Dec_Start,
  input  logic              Init_Finish,
  input  logic              Shuf_Finish,
  input  logic              Dec_Finish,
  input  logic              Dec_Pass,
  output logic              Finish_ack,
  output logic [KEY_W-1:0]  Secret_Key,
  input  logic [ADDR_W-1:0] Init_Address,
  input  logic [DATA_W-1:0] Init_data,
  input  logic              Init_wren,
  input  logic [ADDR_W-1:0] Shuf_Address,
  input  logic [DATA_W-1:0] Shuf_data,
  input  logic              Shuf_wren,
  input  logic [ADDR_W-1:0] Dec_Address,
  input  logic [DATA_W-1:0] Dec_data,
  input  logic              Dec_wren,
  output logic [ADDR_W-1:0] S_Address,
  output logic [DATA_W-1:0] S_data,
  output logic              S_wren,
  output logic              Done,
  output logic              Found,
  output logic              Timeout
);

  seq_state_e       state_q, state_d;
  task_sel_e        task_sel_q, task_sel_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             timeout_q, timeout_d;
  logic             wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      task_sel_q <= TASK_NONE;
      key_q      <= '0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      task_sel_q <= task_sel_d;
      key_q      <= key_d;
      done_q     <= done_d;
      found_q    <= found_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    done_d     = done_q;
    found_d    = found_q;
    timeout_d  = timeout_q;
    Init_Start = 1'b0;
    Shuf_Start = 1'b0;
    Dec_Start  = 1'b0;
    Finish_ack = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          key_d     = '0;
          done_d    = 1'b0;
          found_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_INIT_GO;
        end
      end
      ST_INIT_GO: begin
        Init_Start = 1'b1;
        state_d    = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (Init_Finish) begin
          Finish_ack = 1'b1;
          state_d    = ST_SHUF_GO;
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          found_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      ST_SHUF_GO: begin
        Shuf_Start = 1'b1;
        state_d    = ST_SHUF_WAIT;
      end
      ST_SHUF_WAIT: begin
        if (Shuf_Finish) begin
          Finish_ack = 1'b1;
          state_d    = ST_DEC_GO;
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          found_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      ST_DEC_GO: begin
        Dec_Start = 1'b1;
        state_d   = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        if (Dec_Finish) begin
          Finish_ack = 1'b1;
          if (Dec_Pass) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            found_d = 1'b1;
          end else begin
            state_d = ST_NEXT_KEY;
          end
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          found_d   = 1'b0;
          timeout_d = 1'b1;
        end
      end
      ST_NEXT_KEY: begin
        // The last candidate ends the search instead of wrapping back to 0.
        if (key_q == KEY_MAX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          found_d = 1'b0;
        end else begin
          key_d   = key_q + KEY_W'(1);
          state_d = ST_INIT_GO;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    task_sel_d = task_of_state(state_d);
  end

`ifdef RC4_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end

  // Counts cycles spent in the current WAIT state; restarts on every entry.
  always_comb begin
    wd_d = '0;
    if ((state_q inside {ST_INIT_WAIT, ST_SHUF_WAIT, ST_DEC_WAIT}) && (state_d == state_q))
      wd_d = wd_q + WD_W'(1);
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign Timeout    = timeout_q;
`else
  logic unused_timeout;

  assign wd_expired     = 1'b0;
  assign unused_timeout = timeout_q | (TIMEOUT_CYCLES == 0);
  assign Timeout        = 1'b0;
`endif

  assign Secret_Key = key_q;
  assign Done       = done_q;
  assign Found      = found_q;

  rc4_sram_mux u_sram_mux (
    .sel       (task_sel_q),
    .init_addr (Init_Address),
    .init_data (Init_data),
    .init_wren (Init_wren),
    .shuf_addr (Shuf_Address),
    .shuf_data (Shuf_data),
    .shuf_wren (Shuf_wren),
    .dec_addr  (Dec_Address),
    .dec_data  (Dec_data),
    .dec_wren  (Dec_wren),
    .s_addr    (S_Address),
    .s_data    (S_data),
    .s_wren    (S_wren)
  );

endmodule

// File: tb/tb_rc4_task_sequencer.sv
// Directed bench for rc4_task_sequencer: two instances (default KEY_MAX and
// KEY_MAX=2) share stimulus, each with its own task responder.
module tb_rc4_task_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [7:0]  init_addr, init_data, shuf_addr, shuf_data, dec_addr, dec_data;
  logic        init_wren, shuf_wren, dec_wren;
  logic [23:0] pass_key;
  logic [1:0]  pass_en;
  logic        resp_en;
  logic [2:0]  frc [2];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        init_start, shuf_start, dec_start;
    logic        init_fin, shuf_fin, dec_fin, dec_pass, ack;
    logic        done, found, tmo, s_wren;
    logic [23:0] key;
    logic [7:0]  s_addr, s_data;
    logic [2:0]  starts;
    logic [2:0]  fin;
    logic [2:0]  cnt [3];
    int n_init = 0;
    int n_shuf = 0;
    int n_dec  = 0;
    int n_ack  = 0;

    assign starts   = {dec_start, shuf_start, init_start};
    assign init_fin = fin[0] | frc[g][0];
    assign shuf_fin = fin[1] | frc[g][1];
    assign dec_fin  = fin[2] | frc[g][2];
    assign dec_pass = pass_en[g] && (key == pass_key);

    rc4_task_sequencer #(
      .KEY_MAX        ((g == 0) ? 24'h3FFFFF : 24'h000002),
      .TIMEOUT_CYCLES (16)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .Start        (start),
      .Init_Start   (init_start),
      .Shuf_Start   (shuf_start),
      .Dec_Start    (dec_start),
      .Init_Finish  (init_fin),
      .Shuf_Finish  (shuf_fin),
      .Dec_Finish   (dec_fin),
      .Dec_Pass     (dec_pass),
      .Finish_ack   (ack),
      .Secret_Key   (key),
      .Init_Address (init_addr),
      .Init_data    (init_data),
      .Init_wren    (init_wren),
      .Shuf_Address (shuf_addr),
      .Shuf_data    (shuf_data),
      .Shuf_wren    (shuf_wren),
      .Dec_Address  (dec_addr),
      .Dec_data     (dec_data),
      .Dec_wren     (dec_wren),
      .S_Address    (s_addr),
      .S_data       (s_data),
      .S_wren       (s_wren),
      .Done         (done),
      .Found        (found),
      .Timeout      (tmo)
    );

    // Each task raises Finish five cycles after its start pulse, holds it until acked.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        fin <= '0;
        for (int t = 0; t < 3; t++) cnt[t] <= '0;
      end else begin
        for (int t = 0; t < 3; t++) begin
          if (starts[t]) cnt[t] <= 3'd5;
          else if (cnt[t] != 0) begin
            cnt[t] <= cnt[t] - 3'd1;
            if (cnt[t] == 3'd1 && resp_en) fin[t] <= 1'b1;
          end
          if (ack && fin[t]) fin[t] <= 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      if (init_start) n_init <= n_init + 1;
      if (shuf_start) n_shuf <= n_shuf + 1;
      if (dec_start)  n_dec  <= n_dec + 1;
      if (ack)        n_ack  <= n_ack + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_both(input int budget);
    int c = 0;
    while (!(g_inst[0].done && g_inst[1].done) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_within_budget", {31'd0, g_inst[0].done && g_inst[1].done}, 32'd1);
  endtask

  int b_init0, b_shuf0, b_dec0, b_ack0, b_init1;
  int c;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    init_addr = 8'h05; init_data = 8'hA5; init_wren = 1'b0;
    shuf_addr = 8'd18; shuf_data = 8'h3C; shuf_wren = 1'b1;
    dec_addr  = 8'h77; dec_data  = 8'h99; dec_wren  = 1'b1;
    pass_key  = 24'd0;
    pass_en   = 2'b00;
    resp_en   = 1'b0;
    frc[0]    = 3'b000;
    frc[1]    = 3'b000;

    // Reset state: everything low, S-RAM port parked at zero.
    repeat (3) @(negedge clk);
    chk("rst_done",    {31'd0, g_inst[0].done}, 32'd0);
    chk("rst_found",   {31'd0, g_inst[0].found}, 32'd0);
    chk("rst_timeout", {31'd0, g_inst[0].tmo}, 32'd0);
    chk("rst_key",     {8'd0, g_inst[0].key}, 32'd0);
    chk("rst_s_wren",  {31'd0, g_inst[0].s_wren}, 32'd0);
    chk("rst_s_addr",  {24'd0, g_inst[0].s_addr}, 32'd0);
    chk("rst_starts",  {29'd0, g_inst[0].starts}, 32'd0);
    chk("rst_ack",     {31'd0, g_inst[0].ack}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {29'd0, g_inst[0].starts}, 32'd0);

    // Manual handshake: port muxing and ignored finishes from inactive tasks.
    pulse_start();
    chk("init_go_pulse", {29'd0, g_inst[0].starts}, 32'd1);
    chk("init_go_key",   {8'd0, g_inst[0].key}, 32'd0);
    chk("init_go_addr",  {24'd0, g_inst[0].s_addr}, 32'h05);
    @(negedge clk);
    frc[0] = 3'b110; frc[1] = 3'b110;
    #1;
    chk("foreign_fin_no_ack", {31'd0, g_inst[0].ack}, 32'd0);
    chk("init_wait_wren",     {31'd0, g_inst[0].s_wren}, 32'd0);
    chk("init_wait_addr",     {24'd0, g_inst[0].s_addr}, 32'h05);
    chk("init_wait_data",     {24'd0, g_inst[0].s_data}, 32'hA5);
    @(negedge clk);
    chk("foreign_fin_no_adv", {29'd0, g_inst[0].starts}, 32'd0);
    frc[0] = 3'b001; frc[1] = 3'b001;
    #1;
    chk("init_fin_ack", {31'd0, g_inst[0].ack}, 32'd1);
    @(negedge clk);
    frc[0] = 3'b000; frc[1] = 3'b000;
    #1;
    chk("shuf_go_pulse", {29'd0, g_inst[0].starts}, 32'd2);
    chk("shuf_go_ack",   {31'd0, g_inst[0].ack}, 32'd0);
    @(negedge clk);
    chk("shuf_wait_addr", {24'd0, g_inst[0].s_addr}, 32'd18);
    chk("shuf_wait_wren", {31'd0, g_inst[0].s_wren}, 32'd1);
    chk("shuf_wait_data", {24'd0, g_inst[0].s_data}, 32'h3C);
    rst = 1'b0;
    #1;
    chk("midrst_addr", {24'd0, g_inst[0].s_addr}, 32'd0);
    chk("midrst_wren", {31'd0, g_inst[0].s_wren}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single pass: key 0 decrypts.
    resp_en = 1'b1; pass_en = 2'b11; pass_key = 24'd0;
    @(negedge clk);
    b_init0 = g_inst[0].n_init; b_shuf0 = g_inst[0].n_shuf;
    b_dec0  = g_inst[0].n_dec;  b_ack0  = g_inst[0].n_ack;
    pulse_start();
    wait_both(300);
    chk("p1_found",  {31'd0, g_inst[0].found}, 32'd1);
    chk("p1_key",    {8'd0, g_inst[0].key}, 32'd0);
    chk("p1_tmo",    {31'd0, g_inst[0].tmo}, 32'd0);
    chk("p1_n_init", g_inst[0].n_init - b_init0, 32'd1);
    chk("p1_n_shuf", g_inst[0].n_shuf - b_shuf0, 32'd1);
    chk("p1_n_dec",  g_inst[0].n_dec - b_dec0, 32'd1);
    chk("p1_n_ack",  g_inst[0].n_ack - b_ack0, 32'd3);
    chk("p1_done_addr", {24'd0, g_inst[0].s_addr}, 32'd0);
    chk("p1_done_wren", {31'd0, g_inst[0].s_wren}, 32'd0);

    // Restart from DONE: dut0 hits key 3, dut1 exhausts KEY_MAX=2.
    pass_en = 2'b01; pass_key = 24'd3;
    b_init0 = g_inst[0].n_init; b_dec0 = g_inst[0].n_dec;
    b_ack0  = g_inst[0].n_ack;  b_init1 = g_inst[1].n_init;
    pulse_start();
    chk("restart_clears_done",  {31'd0, g_inst[0].done}, 32'd0);
    chk("restart_clears_found", {31'd0, g_inst[0].found}, 32'd0);
    wait_both(1000);
    chk("p4_found",   {31'd0, g_inst[0].found}, 32'd1);
    chk("p4_key",     {8'd0, g_inst[0].key}, 32'h000003);
    chk("p4_n_init",  g_inst[0].n_init - b_init0, 32'd4);
    chk("p4_n_dec",   g_inst[0].n_dec - b_dec0, 32'd4);
    chk("p4_n_ack",   g_inst[0].n_ack - b_ack0, 32'd12);
    chk("kmax_found", {31'd0, g_inst[1].found}, 32'd0);
    chk("kmax_key",   {8'd0, g_inst[1].key}, 32'd2);
    chk("kmax_n_init", g_inst[1].n_init - b_init1, 32'd3);

    // Reset while shuffling key 2, then a fresh search starts at key 0.
    pass_en = 2'b00;
    pulse_start();
    c = 0;
    while (!(g_inst[0].key == 24'd2 && g_inst[0].shuf_start) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("reach_key2_shuf", {31'd0, g_inst[0].shuf_start}, 32'd1);
    @(negedge clk);
    chk("key2_shuf_addr", {24'd0, g_inst[0].s_addr}, 32'd18);
    rst = 1'b0;
    #1;
    b_init0 = g_inst[0].n_init; b_ack0 = g_inst[0].n_ack;
    chk("rst2_key",  {8'd0, g_inst[0].key}, 32'd0);
    chk("rst2_addr", {24'd0, g_inst[0].s_addr}, 32'd0);
    chk("rst2_ack",  {31'd0, g_inst[0].ack}, 32'd0);
    chk("rst2_done", {31'd0, g_inst[0].done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst2_no_resume", g_inst[0].n_init - b_init0, 32'd0);
    chk("rst2_no_ack",    g_inst[0].n_ack - b_ack0, 32'd0);
    pass_en = 2'b11; pass_key = 24'd0;
    pulse_start();
    chk("rst2_restart_key",   {8'd0, g_inst[0].key}, 32'd0);
    chk("rst2_restart_pulse", {29'd0, g_inst[0].starts}, 32'd1);
    wait_both(300);
    chk("rst2_found", {31'd0, g_inst[0].found}, 32'd1);

    // Init task never finishes.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; resp_en = 1'b0; pass_en = 2'b00;
    b_ack0 = g_inst[0].n_ack;
    pulse_start();
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("wd_before_limit", {31'd0, g_inst[0].done}, 32'd0);
    @(negedge clk);
`ifdef RC4_SEQ_TIMEOUT_EN
    chk("wd_done",    {31'd0, g_inst[0].done}, 32'd1);
    chk("wd_timeout", {31'd0, g_inst[0].tmo}, 32'd1);
    chk("wd_found",   {31'd0, g_inst[0].found}, 32'd0);
`else
    chk("nowd_done",    {31'd0, g_inst[0].done}, 32'd0);
    chk("nowd_timeout", {31'd0, g_inst[0].tmo}, 32'd0);
    repeat (40) @(negedge clk);
    chk("nowd_still_waiting", {31'd0, g_inst[0].done}, 32'd0);
`endif
    chk("wd_no_ack", g_inst[0].n_ack - b_ack0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
